// File: rtl/clock_divider_prog.sv
// Multi-channel runtime-programmable clock divider: each channel emits a registered
// near-50% divided clock and a one-cycle tick per period; divisor changes land on period boundaries.
module clock_divider_prog #(
  parameter int N_CH        = 2,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 128,
  parameter bit TEST_MODE   = 1'b0
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic [N_CH-1:0]         enable,
  input  logic [N_CH-1:0]         div_load,
  input  logic [N_CH*DIV_W-1:0]   div_in,
  output logic [N_CH-1:0]         clk_out,
  output logic [N_CH-1:0]         tick,
  output logic [N_CH-1:0]         load_pending
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pending_q, pending_d;
    logic             running_q, running_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    logic [DIV_W:0]   cnt_inc;
    logic [DIV_W:0]   high_len;
    logic [DIV_W-1:0] next_div;
    logic             boundary;

    // A zero divisor is treated as a boundary on every edge so that a pending
    // load is picked up immediately and acts as a fresh start.
    assign cnt_inc  = {1'b0, cnt_q} + (DIV_W+1)'(1);
    assign high_len = {1'b0, cur_div_q} - {2'b00, cur_div_q[DIV_W-1:1]};
    assign next_div = pending_q ? pend_div_q : cur_div_q;
    assign boundary = !running_q || (cur_div_q == '0) ||
                      (cnt_q == cur_div_q - DIV_W'(1));

    always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      cnt_d      = cnt_q;
      cur_div_d  = cur_div_q;
      pend_div_d = pend_div_q;
      pending_d  = pending_q;
      running_d  = running_q;
      clk_d      = clk_q;
      tick_d     = tick_q;

      if (!enable[i]) begin
        cnt_d     = '0;
        running_d = 1'b0;
        clk_d     = 1'b0;
        tick_d    = 1'b0;
      end else if (boundary) begin
        running_d = 1'b1;
        cnt_d     = '0;
        cur_div_d = next_div;
        pending_d = 1'b0;
        clk_d     = (next_div != '0);
        tick_d    = (next_div != '0);
      end else begin
        cnt_d  = cnt_inc[DIV_W-1:0];
        clk_d  = (cnt_inc < high_len);
        tick_d = 1'b0;
      end

      // A load on the applying edge is captured after the old value was consumed.
      if (div_load[i]) begin
        pend_div_d = div_in[i*DIV_W +: DIV_W];
        pending_d  = 1'b1;
      end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
        cnt_q      <= '0;
        cur_div_q  <= DIV_W'(DEFAULT_DIV);
        pend_div_q <= '0;
        pending_q  <= 1'b0;
        running_q  <= 1'b0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        cnt_q      <= cnt_d;
        cur_div_q  <= cur_div_d;
        pend_div_q <= pend_div_d;
        pending_q  <= pending_d;
        running_q  <= running_d;
        clk_q      <= clk_d;
        tick_q     <= tick_d;
      end
    end

    assign load_pending[i] = pending_q;

    if (TEST_MODE) begin : g_test
      assign clk_out[i] = clk_in;
      assign tick[i]    = 1'b1;
    end else begin : g_norm
      assign clk_out[i] = clk_q;
      assign tick[i]    = tick_q;
    end
  end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Randomized scoreboard bench for clock_divider_prog: a period-position reference model
// pushes expected outputs per edge; a negedge monitor pops and compares.
module tb_clock_divider_prog;
  localparam int N_CH  = 2;
  localparam int DIV_W = 16;
  localparam int DEF   = 128;

  logic                  clk_in = 1'b0;
  logic                  reset;
  logic [N_CH-1:0]       enable;
  logic [N_CH-1:0]       div_load;
  logic [N_CH*DIV_W-1:0] div_in;
  logic [N_CH-1:0]       clk_out;
  logic [N_CH-1:0]       tick;
  logic [N_CH-1:0]       load_pending;

  always #5 clk_in = ~clk_in;

  clock_divider_prog #(
    .N_CH(N_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEF), .TEST_MODE(1'b0)
  ) dut (
    .clk_in(clk_in), .reset(reset), .enable(enable), .div_load(div_load),
    .div_in(div_in), .clk_out(clk_out), .tick(tick), .load_pending(load_pending)
  );

  typedef struct packed {
    logic [1:0] clk;
    logic [1:0] tk;
    logic [1:0] lp;
  } exp_t;

  exp_t  sb_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "init";

  // Reference model: each channel is described by its position within the current
  // period and the divisor of that period; outputs follow from position alone.
  bit m_run[N_CH];
  int m_pos[N_CH];
  int m_d[N_CH];
  bit m_pend[N_CH];
  int m_pendv[N_CH];
  logic [1:0] m_clk, m_tk, m_lp;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got clk/tick/pend=%b required %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_run[c] = 0; m_pos[c] = 0; m_d[c] = DEF; m_pend[c] = 0; m_pendv[c] = 0;
    end
    m_clk = '0; m_tk = '0; m_lp = '0;
  endfunction

  function automatic void model_edge(input logic [1:0] en, input logic [1:0] ld,
                                     input logic [31:0] dv);
    for (int c = 0; c < N_CH; c++) begin
      if (!en[c]) begin
        m_run[c] = 0; m_pos[c] = 0;
        m_clk[c] = 0; m_tk[c] = 0;
      end else begin
        if (!m_run[c] || m_d[c] == 0 || m_pos[c] == m_d[c] - 1) begin
          if (m_pend[c]) begin
            m_d[c] = m_pendv[c];
            m_pend[c] = 0;
          end
          m_run[c] = 1;
          m_pos[c] = 0;
        end else begin
          m_pos[c] = m_pos[c] + 1;
        end
        m_clk[c] = (m_d[c] != 0) && (m_pos[c] < (m_d[c] + 1) / 2);
        m_tk[c]  = (m_d[c] != 0) && (m_pos[c] == 0);
      end
      if (ld[c]) begin
        m_pendv[c] = int'(dv[c*DIV_W +: DIV_W]);
        m_pend[c]  = 1;
      end
      m_lp[c] = m_pend[c];
    end
  endfunction

  task automatic step(input logic [1:0] en, input logic [1:0] ld, input logic [31:0] dv);
    exp_t e;
    enable = en; div_load = ld; div_in = dv;
    @(posedge clk_in);
    #1;
    model_edge(en, ld, dv);
    e.clk = m_clk; e.tk = m_tk; e.lp = m_lp;
    sb_q.push_back(e);
    div_load = '0;
  endtask

  task automatic run(input int n, input logic [1:0] en);
    repeat (n) step(en, 2'b00, 32'd0);
  endtask

  function automatic logic [31:0] dv1(input int v);
    return {16'(v), 16'd0};
  endfunction

  // Monitor: the DUT presents outputs every cycle; compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(phase, {clk_out, tick, load_pending}, e);
      end
    end
  end

  initial begin
    logic [1:0] en;
    reset = 1'b1; enable = '0; div_load = '0; div_in = '0;
    model_reset();
    #12;
    check("reset_state", {clk_out, tick, load_pending}, 6'b0);
    @(posedge clk_in); #1 reset = 1'b0;

    phase = "ch0_default";
    run(300, 2'b01);

    phase = "ch1_load5_disabled";
    step(2'b01, 2'b10, dv1(5));
    run(3, 2'b01);
    run(20, 2'b11);

    phase = "ch0_load4_at_cnt10";
    for (int k = 0; k < 200 && m_pos[0] != 10; k++) step(2'b11, 2'b00, 32'd0);
    check("ch0_reached_cnt10", 6'(m_pos[0]), 6'd10);
    step(2'b11, 2'b01, 32'd4);
    run(140, 2'b11);

    phase = "ch1_last_wins";
    for (int k = 0; k < 20 && m_pos[1] != 0; k++) step(2'b11, 2'b00, 32'd0);
    step(2'b11, 2'b10, dv1(7));
    step(2'b11, 2'b10, dv1(3));
    for (int k = 0; k < 20 && m_pos[1] != m_d[1] - 1; k++) step(2'b11, 2'b00, 32'd0);
    step(2'b11, 2'b10, dv1(2));
    run(20, 2'b11);

    phase = "ch1_div1_div0_div6";
    step(2'b11, 2'b10, dv1(1));
    run(12, 2'b11);
    step(2'b11, 2'b10, dv1(0));
    run(10, 2'b11);
    step(2'b11, 2'b10, dv1(6));
    run(20, 2'b11);

    phase = "random";
    en = 2'b11;
    repeat (3000) begin
      logic [1:0] ld;
      logic [31:0] dv;
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 49) == 0) en[c] = ~en[c];
        ld[c] = ($urandom_range(0, 9) == 0);
      end
      dv = {16'($urandom_range(0, 12)), 16'($urandom_range(0, 12))};
      step(en, ld, dv);
    end

    phase = "reset_mid_period";
    step(2'b11, 2'b11, {16'd3, 16'd20});
    run(45, 2'b11);
    for (int k = 0; k < 40 && m_pos[0] != 1; k++) step(2'b11, 2'b00, 32'd0);
    step(2'b11, 2'b01, 32'd9);
    @(negedge clk_in); #1;
    check("pre_reset_clk_high", {5'b0, clk_out[0]}, 6'b1);
    reset = 1'b1;
    #1;
    check("reset_async_drop", {clk_out, tick, load_pending}, 6'b0);
    model_reset();
    #20;
    @(negedge clk_in); reset = 1'b0;
    phase = "after_reset_default";
    run(300, 2'b01);

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk_in);
    @(negedge clk_in); #1;
    check("scoreboard_drained", 6'(sb_q.size()), 6'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
- Multi-channel, runtime-programmable clock divider; successor to the fixed divide-by-128 divider.
- Each of N_CH channels produces:
  - a near-50%-duty divided clock, registered in the clk_in domain;
  - a one-cycle tick strobe marking each divided period.
- Divisors are programmed per channel. A new divisor takes effect glitch-free at the next period boundary.
- Sits between the board clock and the slow-timing consumers (sampling, display refresh, UART baud).

Parameters:
- N_CH, 2, number of independent divider channels (1..8).
- DIV_W, 16, width of each divisor value.
- DEFAULT_DIV, 128, divisor loaded into every channel at reset (1.28 us period at 100 MHz).
- TEST_MODE, 0, when 1, every clk_out follows clk_in combinationally and every tick is constant 1, for fast simulation.

Ports:
- clk_in, input, 1, system clock.
- reset, input, 1, asynchronous, active-high reset.
- enable, input, N_CH, per-channel run enable.
- div_load, input, N_CH, per-channel one-cycle strobe that captures a new divisor.
- div_in, input, N_CH*DIV_W, divisor values; channel i uses bits [i*DIV_W +: DIV_W].
- clk_out, output, N_CH, divided clocks, registered.
- tick, output, N_CH, one-cycle strobe at the start of each divided period, registered.
- load_pending, output, N_CH, high while a captured divisor awaits its boundary.

Behaviour:
- Reset (asynchronous, every channel):
  - cnt=0, cur_div=DEFAULT_DIV, pend_div=0, load_pending=0, running=0, clk_out=0, tick=0.
- Per-channel state: cnt (DIV_W bits), cur_div, pend_div, load_pending, running. Let D=cur_div and H=D-floor(D/2), the high-phase length (ceil(D/2)).
- Disabled (enable=0) at a clock edge: cnt<=0, running<=0, clk_out<=0, tick<=0. The stop is immediate, with no waiting for the period to end.
- Start: the first edge with enable=1 while running=0 sets:
  - running<=1, cnt<=0, clk_out<=1, tick<=1;
  - cur_div<=pend_div if load_pending, and clears load_pending.
- Running, cnt==D-1 (wrap): cnt<=0, clk_out<=1, tick<=1. The pending divisor is applied here and load_pending is cleared.
- Running, otherwise: cnt<=cnt+1, clk_out<=(cnt+1 < H), tick<=0.
- Resulting waveform: clk_out is high for H cycles and low for floor(D/2) cycles. The period is exactly D clk_in cycles. tick is high in the first high cycle of clk_out.
- Degenerate divisors:
  - D=1: clk_out stays 1 and tick=1 on every running cycle.
  - D=0: channel treated as stopped. clk_out=0, tick=0, cnt held 0. A pending load is still applied on the next edge, which then acts as a start.
- Divisor loads:
  - div_load[i] captures the div_in slice into pend_div and sets load_pending. It never alters cur_div mid-period.
  - A second load before the boundary overwrites pend_div; the last one wins.
  - Load and wrap on the same edge: the wrap applies the old pend_div, and the new value is captured and stays pending.
  - Load while disabled: held pending and applied at the start edge.
- Channels are fully independent; no shared counter.
- TEST_MODE=1: clk_out[i]=clk_in, tick[i]=1, load_pending tracks loads as normal. All counting logic is ignored for the outputs.
- Reset mid-period: outputs drop to reset values immediately, asynchronously. cur_div returns to DEFAULT_DIV and any pending load is discarded.

Test Plan:
- Reset release, enable=2'b01, no loads -> ch0 clk_out has a 128-cycle period, high 64 / low 64, tick once per 128 cycles. ch1 clk_out=0, tick=0.
- Load D=5 on ch1 while disabled, then enable -> load_pending=1 until the start edge. clk_out pattern is 1,1,1,0,0 repeating, tick every 5 cycles starting on the enable edge.
- Running ch0 at D=128, load D=4 at cnt=10 -> old period completes (118 more cycles). A tick then starts the D=4 pattern 1,1,0,0. load_pending falls on that same edge.
- Two loads (7, then 3) before the boundary; also a load on the wrap edge -> only 3 is applied. The wrap-edge load remains pending and applies at the following boundary.
- Divisor 1 and divisor 0 -> D=1: clk_out and tick constantly 1. D=0: both constantly 0. Loading D=6 afterwards restarts with tick on the next edge.
- Assert reset mid-period with clk_out=1 -> clk_out and tick go 0 without a clock edge. After release, the channel runs at 128 and earlier pending loads are discarded.
